// File: rtl/commit_writeback_pkg.sv
// Common types and sizes for the commit/writeback reorder stage.
`include "commit_writeback_defines.sv"

package commit_writeback_pkg;
    localparam int ID_W  = `COMMIT_ID_WIDTH;
    localparam int REG_W = `REG_IDX_WIDTH;
    localparam int DEPTH = 1 << ID_W;
    // one extra bit so a completely full buffer (DEPTH) is representable
    localparam int CNT_W = ID_W + 1;

    typedef logic [ID_W-1:0]  commit_id_t;
    typedef logic [REG_W-1:0] reg_idx_t;
    typedef logic [CNT_W-1:0] slot_cnt_t;
endpackage

// File: rtl/commit_writeback_defines.sv
// Shared defines: commit tag width and register-file index width.
`ifndef COMMIT_WRITEBACK_DEFINES_SV
`define COMMIT_WRITEBACK_DEFINES_SV
`define COMMIT_ID_WIDTH 3
`define REG_IDX_WIDTH 4
`endif

// File: rtl/result_narrow.sv
// Narrows a wide signed accumulator result to the written-back sample width.
// COMMIT_WRITEBACK_SATURATE_EN defined: clamp to the signed data_width range.
// Otherwise: plain two's-complement truncation of the upper bits.
module result_narrow #(
    parameter int data_width = 16,
    parameter int full_width = 2*data_width+8
) (
    input  logic signed [full_width-1:0] din,
    output logic signed [data_width-1:0] dout
);
`ifdef COMMIT_WRITEBACK_SATURATE_EN
    localparam logic signed [full_width-1:0] MAX_V =
        {{(full_width-data_width+1){1'b0}}, {(data_width-1){1'b1}}};
    localparam logic signed [full_width-1:0] MIN_V =
        {{(full_width-data_width+1){1'b1}}, {(data_width-1){1'b0}}};

    // clamp into the representable range, otherwise pass the low bits through
    always_comb begin
        dout = din[data_width-1:0];
        if (din > MAX_V)
            dout = MAX_V[data_width-1:0];
        else if (din < MIN_V)
            dout = MIN_V[data_width-1:0];
    end
`else
    // upper bits are intentionally discarded by truncation
    logic unused_hi;
    assign unused_hi = ^din[full_width-1:data_width];

    // truncate to the low data_width bits
    always_comb begin
        dout = din[data_width-1:0];
    end
`endif
endmodule

// File: rtl/commit_writeback.sv
// Reorder buffer that accepts results tagged by commit_id in any order and
// writes them back to the register file strictly in tag order, one per cycle.
// Optional build macro: COMMIT_WRITEBACK_SATURATE_EN (clamping narrowing).
module commit_writeback
    import commit_writeback_pkg::*;
#(
    parameter int data_width = 16,
    parameter int n_blocks   = 256,
    parameter int full_width = 2*data_width+8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [$clog2(n_blocks)-1:0]   block_in,
    input  logic signed [full_width-1:0]  result_in,
    input  logic [REG_W-1:0]              dest_in,
    input  logic [ID_W-1:0]               commit_id_in,
    input  logic                          commit_flag_in,
    output logic                          wr_en,
    output logic [$clog2(n_blocks)-1:0]   wr_block,
    output logic [REG_W-1:0]              wr_dest,
    output logic signed [data_width-1:0]  wr_data,
    output logic                          commit_done,
    output logic [ID_W-1:0]               commit_id_out,
    output logic                          id_collision
);
    localparam int BLK_W = $clog2(n_blocks);

    // slot storage, indexed directly by commit tag
    logic [DEPTH-1:0]              valid_q, valid_d;
    logic [DEPTH-1:0]              flag_q, flag_d;
    logic [BLK_W-1:0]              blk_q [DEPTH];
    logic [BLK_W-1:0]              blk_d [DEPTH];
    logic signed [data_width-1:0]  data_q [DEPTH];
    logic signed [data_width-1:0]  data_d [DEPTH];
    reg_idx_t                      dest_q [DEPTH];
    reg_idx_t                      dest_d [DEPTH];

    commit_id_t                    head_q, head_d;
    slot_cnt_t                     count_q, count_d;
    logic                          coll_q, coll_d;

    logic                          wr_en_q, wr_en_d;
    logic                          done_q, done_d;
    logic [BLK_W-1:0]              wr_block_q, wr_block_d;
    reg_idx_t                      wr_dest_q, wr_dest_d;
    logic signed [data_width-1:0]  wr_data_q, wr_data_d;
    commit_id_t                    id_out_q, id_out_d;

    logic signed [data_width-1:0]  narrowed;
    logic                          xfer, retire, slot_busy, inc;

    result_narrow #(
        .data_width (data_width),
        .full_width (full_width)
    ) u_narrow (
        .din  (result_in),
        .dout (narrowed)
    );

    assign in_ready  = enable && (count_q < slot_cnt_t'(DEPTH));
    assign xfer      = in_valid && in_ready;
    assign retire    = enable && valid_q[head_q];
    // target slot stays occupied after this edge unless it is the one retiring
    assign slot_busy = valid_q[commit_id_in] && !(retire && (commit_id_in == head_q));
    assign inc       = xfer && !slot_busy;

    // next-state: retire the head slot, then apply any incoming write
    always_comb begin
        valid_d    = valid_q;
        flag_d     = flag_q;
        blk_d      = blk_q;
        data_d     = data_q;
        dest_d     = dest_q;
        head_d     = head_q;
        count_d    = count_q;
        coll_d     = coll_q;
        wr_en_d    = 1'b0;
        done_d     = 1'b0;
        wr_block_d = wr_block_q;
        wr_dest_d  = wr_dest_q;
        wr_data_d  = wr_data_q;
        id_out_d   = id_out_q;

        if (retire) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
            wr_en_d         = 1'b1;
            done_d          = flag_q[head_q];
            wr_block_d      = blk_q[head_q];
            wr_dest_d       = dest_q[head_q];
            wr_data_d       = data_q[head_q];
            id_out_d        = head_q;
        end

        if (xfer) begin
            valid_d[commit_id_in] = 1'b1;
            flag_d[commit_id_in]  = commit_flag_in;
            blk_d[commit_id_in]   = block_in;
            data_d[commit_id_in]  = narrowed;
            dest_d[commit_id_in]  = dest_in;
            if (valid_q[commit_id_in])
                coll_d = 1'b1;
        end

        case ({inc, retire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // state registers, all cleared asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= '0;
            flag_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                blk_q[i]  <= '0;
                data_q[i] <= '0;
                dest_q[i] <= '0;
            end
            head_q     <= '0;
            count_q    <= '0;
            coll_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b0;
            wr_block_q <= '0;
            wr_dest_q  <= '0;
            wr_data_q  <= '0;
            id_out_q   <= '0;
        end else begin
            valid_q    <= valid_d;
            flag_q     <= flag_d;
            blk_q      <= blk_d;
            data_q     <= data_d;
            dest_q     <= dest_d;
            head_q     <= head_d;
            count_q    <= count_d;
            coll_q     <= coll_d;
            wr_en_q    <= wr_en_d;
            done_q     <= done_d;
            wr_block_q <= wr_block_d;
            wr_dest_q  <= wr_dest_d;
            wr_data_q  <= wr_data_d;
            id_out_q   <= id_out_d;
        end
    end

    assign wr_en         = wr_en_q;
    assign commit_done   = done_q;
    assign wr_block      = wr_block_q;
    assign wr_dest       = wr_dest_q;
    assign wr_data       = wr_data_q;
    assign commit_id_out = id_out_q;
    assign id_collision  = coll_q;
endmodule

// File: tb/tb_commit_writeback.sv
// Scoreboard bench for commit_writeback: a tag-indexed array model predicts
// each retirement; a negedge monitor pops and compares whatever the DUT writes.
module tb_commit_writeback;
    import commit_writeback_pkg::*;

    localparam int DW    = 16;
    localparam int NB    = 256;
    localparam int FW    = 2*DW+8;
    localparam int BLK_W = $clog2(NB);

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                enable = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [BLK_W-1:0]    block_in = '0;
    logic signed [FW-1:0] result_in = '0;
    logic [REG_W-1:0]    dest_in = '0;
    logic [ID_W-1:0]     commit_id_in = '0;
    logic                commit_flag_in = 1'b0;
    logic                wr_en;
    logic [BLK_W-1:0]    wr_block;
    logic [REG_W-1:0]    wr_dest;
    logic signed [DW-1:0] wr_data;
    logic                commit_done;
    logic [ID_W-1:0]     commit_id_out;
    logic                id_collision;

    commit_writeback #(.data_width(DW), .n_blocks(NB), .full_width(FW)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready),
        .block_in(block_in), .result_in(result_in), .dest_in(dest_in),
        .commit_id_in(commit_id_in), .commit_flag_in(commit_flag_in),
        .wr_en(wr_en), .wr_block(wr_block), .wr_dest(wr_dest), .wr_data(wr_data),
        .commit_done(commit_done), .commit_id_out(commit_id_out),
        .id_collision(id_collision)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint blk;
        longint dest;
        longint data;
        longint id;
        bit     done;
    } rec_t;

    int     n_chk = 0;
    int     n_fail = 0;
    rec_t   q[$];
    rec_t   exp_last;
    bit     exp_wr_en = 1'b0;

    // reference model: one entry per tag, head pointer, occupancy count
    bit     mvalid [DEPTH];
    bit     mflag  [DEPTH];
    longint mblk   [DEPTH];
    longint mdest  [DEPTH];
    longint mdata  [DEPTH];
    int     mhead = 0;
    int     mcount = 0;
    bit     mcoll = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint narrow(input longint r);
        longint hi, lo, m;
        hi = (64'sd1 <<< (DW-1)) - 1;
        lo = -(64'sd1 <<< (DW-1));
`ifdef COMMIT_WRITEBACK_SATURATE_EN
        if (r > hi) return hi;
        if (r < lo) return lo;
        return r;
`else
        m = r & ((64'sd1 <<< DW) - 1);
        if (m > hi) m = m - (64'sd1 <<< DW);
        if (lo > 0) m = lo; // never taken; keeps lo referenced in this build
        return m;
`endif
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            mvalid[i] = 1'b0;
            mflag[i]  = 1'b0;
            mblk[i]   = 0;
            mdest[i]  = 0;
            mdata[i]  = 0;
        end
        mhead  = 0;
        mcount = 0;
        mcoll  = 1'b0;
    endfunction

    // one cycle: drive inputs after negedge, predict the coming posedge
    task automatic step(input bit v, input bit en, input int id, input longint res,
                        input int blk, input int dest, input bit flag);
        bit rdy, xfer, ret, pre;
        int sid;
        longint rv;
        @(negedge clk);
        #1;
        sid = ((id % DEPTH) + DEPTH) % DEPTH;
        rv  = res;
        in_valid       = v;
        enable         = en;
        commit_id_in   = sid[ID_W-1:0];
        result_in      = rv[FW-1:0];
        block_in       = blk[BLK_W-1:0];
        dest_in        = dest[REG_W-1:0];
        commit_flag_in = flag;
        #1;
        rdy = en && (mcount < DEPTH);
        chk("in_ready", longint'(in_ready), longint'(rdy));
        xfer = v && rdy;
        ret  = en && mvalid[mhead];
        pre  = mvalid[sid];
        if (ret) begin
            q.push_back('{mblk[mhead], mdest[mhead], mdata[mhead], longint'(mhead), mflag[mhead]});
            mvalid[mhead] = 1'b0;
            mhead  = (mhead + 1) % DEPTH;
            mcount = mcount - 1;
        end
        exp_wr_en = ret;
        if (xfer) begin
            if (pre) mcoll = 1'b1;
            if (!mvalid[sid]) mcount = mcount + 1;
            mvalid[sid] = 1'b1;
            mflag[sid]  = flag;
            mblk[sid]   = longint'(blk % NB);
            mdest[sid]  = longint'(dest % 16);
            mdata[sid]  = narrow(res);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b1, 0, 0, 0, 0, 1'b0);
    endtask

    // assert reset between clock edges and check outputs clear immediately
    task automatic do_reset_async();
        @(negedge clk);
        #2;
        reset    = 1'b1;
        in_valid = 1'b0;
        enable   = 1'b0;
        #1;
        chk("rst_wr_en", longint'(wr_en), 0);
        chk("rst_commit_done", longint'(commit_done), 0);
        chk("rst_id_collision", longint'(id_collision), 0);
        chk("rst_wr_block", longint'(wr_block), 0);
        chk("rst_wr_dest", longint'(wr_dest), 0);
        chk("rst_wr_data", longint'(wr_data), 0);
        chk("rst_commit_id_out", longint'(commit_id_out), 0);
        model_clear();
        q.delete();
        exp_wr_en = 1'b0;
        exp_last  = '{0, 0, 0, 0, 1'b0};
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    // monitor: compare every cycle, popping the scoreboard on each write strobe
    always @(negedge clk) begin
        chk("wr_en", longint'(wr_en), longint'(exp_wr_en));
        if (exp_wr_en) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL scoreboard: got empty queue, expected an entry (t=%0t)", $time);
            end else begin
                exp_last = q.pop_front();
            end
        end
        chk("wr_block", longint'(wr_block), exp_last.blk);
        chk("wr_dest", longint'(wr_dest), exp_last.dest);
        chk("wr_data", longint'(wr_data), exp_last.data);
        chk("commit_id_out", longint'(commit_id_out), exp_last.id);
        chk("commit_done", longint'(commit_done), longint'(exp_wr_en && exp_last.done));
        chk("id_collision", longint'(id_collision), longint'(mcoll));
    end

    initial begin
        int h;
        longint r;
        model_clear();
        exp_last = '{0, 0, 0, 0, 1'b0};
        do_reset_async();

        // in-order group of three, flag on the last
        step(1'b1, 1'b1, 0, 5, 10, 1, 1'b0);
        step(1'b1, 1'b1, 1, -3, 11, 2, 1'b0);
        step(1'b1, 1'b1, 2, 7, 12, 3, 1'b1);
        idle(4);

        // out of order: head+2, head, head+1
        h = mhead;
        step(1'b1, 1'b1, h + 2, 300, 20, 4, 1'b1);
        idle(2);
        step(1'b1, 1'b1, h, 100, 21, 5, 1'b0);
        step(1'b1, 1'b1, h + 1, 200, 22, 6, 1'b0);
        idle(5);

        // narrowing boundaries
        h = mhead;
        step(1'b1, 1'b1, h, 40000, 1, 7, 1'b0);
        step(1'b1, 1'b1, h + 1, -40000, 2, 8, 1'b0);
        step(1'b1, 1'b1, h + 2, 32767, 3, 9, 1'b0);
        step(1'b1, 1'b1, h + 3, -32768, 4, 10, 1'b0);
        step(1'b1, 1'b1, h + 4, 32768, 5, 11, 1'b1);
        idle(4);

        // fill every non-head slot, then head: buffer full, in_ready low
        h = mhead;
        for (int k = 1; k < DEPTH; k++) step(1'b1, 1'b1, h + k, k * 11, k, k, 1'b0);
        step(1'b1, 1'b1, h, 999, 30, 12, 1'b1);
        step(1'b1, 1'b1, h, 555, 31, 13, 1'b0);
        step(1'b1, 1'b1, h, 556, 32, 14, 1'b0);
        idle(DEPTH + 3);

        // enable low freezes accept and retire
        h = mhead;
        step(1'b1, 1'b1, h, 77, 40, 1, 1'b0);
        step(1'b1, 1'b0, h + 1, 78, 41, 2, 1'b0);
        step(1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
        step(1'b1, 1'b1, h + 1, 79, 42, 3, 1'b1);
        idle(3);

        // duplicate tag 3 from a clean start: collision, second payload wins
        do_reset_async();
        step(1'b1, 1'b1, 3, 1111, 50, 1, 1'b0);
        step(1'b1, 1'b1, 3, 2222, 51, 2, 1'b1);
        step(1'b1, 1'b1, 0, 10, 52, 3, 1'b0);
        step(1'b1, 1'b1, 1, 11, 53, 4, 1'b0);
        step(1'b1, 1'b1, 2, 12, 54, 5, 1'b0);
        idle(6);

        // reset with three entries pending, then tag 0 retires normally
        h = mhead;
        step(1'b1, 1'b1, h + 1, 61, 60, 1, 1'b0);
        step(1'b1, 1'b1, h + 2, 62, 61, 2, 1'b0);
        step(1'b1, 1'b1, h + 3, 63, 62, 3, 1'b0);
        do_reset_async();
        step(1'b1, 1'b1, 0, 64, 63, 4, 1'b1);
        idle(4);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            int id;
            case ($urandom_range(0, 3))
                0:       r = 40000;
                1:       r = -40000;
                default: r = longint'($urandom_range(0, 2000000)) - 1000000;
            endcase
            id = ($urandom_range(0, 1) == 0) ? mhead : int'($urandom_range(0, DEPTH-1));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) != 0, id, r,
                 int'($urandom_range(0, NB-1)), int'($urandom_range(0, 15)),
                 $urandom_range(0, 3) == 0);
        end
        idle(DEPTH + 4);
        chk("queue_empty", longint'(q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
